alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage and a multi-cycle helper unit such as a CSR or address-generation sequencer.
- Round-robin grant with a valid/ready request channel and a valid/ready response channel per requester.
- Holds ALU operands and opcode in registers for one full evaluation cycle, then captures ALUResult and BIT_Branch into a response register.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between requesters
//
// Purpose: accepts one request at a time from NUM_REQ requesters (round-robin),
// registers its operands/opcode onto the ALU for one cycle, captures the ALU
// result/branch flag and returns it on the owner's response channel.
// Optional macro: ALU_ARB_STATS_EN adds per-requester saturating grant counters.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake, one bit per requester
//   req_op1/req_op2/req_ctrl   per-requester operands and opcode
//   rsp_valid/rsp_ready        response handshake, one bit per requester
//   rsp_result/rsp_branch      captured ALU outputs, shared by all requesters
//   alu_op1/alu_op2/alu_ctrl   registered ALU inputs
//   alu_result/alu_branch      ALU outputs
//   stat_grant_cnt, stat_clr   grant counters and their clear (ALU_ARB_STATS_EN only)

package my_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_ops_t;
endpackage

module alu_arbiter
    import my_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef ALU_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]     stat_grant_cnt,
    input  logic                      stat_clr,
`endif
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    input  alu_ops_t                  req_ctrl [NUM_REQ],
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_branch,
    output logic [DATA_W-1:0]         alu_op1,
    output logic [DATA_W-1:0]         alu_op2,
    output alu_ops_t                  alu_ctrl,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_branch
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_found;
    logic             accept;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is only ever raised toward a valid requester, so
                // raising it is itself the accept.
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_ctrl   <= ALU_ADD;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
        end else begin
            if (accept) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
                alu_op1    <= req_op1[grant_idx*DATA_W +: DATA_W];
                alu_op2    <= req_op2[grant_idx*DATA_W +: DATA_W];
                alu_ctrl   <= req_ctrl[grant_idx];
            end
            // ALU inputs have been stable for the whole EXEC cycle.
            if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_branch <= alu_branch;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stat_clr) begin
                    stat_grant_cnt[i*16 +: 16] <= 16'd0;
                end else if (accept && (grant_idx == IDX_W'(i)) &&
                             (stat_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    stat_grant_cnt[i*16 +: 16] <= stat_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;
    import my_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_op1 = '0;
    logic [63:0] req_op2 = '0;
    alu_ops_t    req_ctrl [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_branch;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    alu_ops_t    alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_branch;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant_cnt;
    logic        stat_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ALU_ARB_STATS_EN
        .stat_grant_cnt (stat_grant_cnt),
        .stat_clr   (stat_clr),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_branch (rsp_branch),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_branch (alu_branch)
    );

    // Stand-in for the shared ALU.
    always_comb begin
        alu_result = '0;
        alu_branch = 1'b0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = alu_op1 + alu_op2;
            ALU_SUB:  alu_result = alu_op1 - alu_op2;
            ALU_XOR:  alu_result = alu_op1 ^ alu_op2;
            ALU_BEQ:  alu_branch = (alu_op1 == alu_op2);
            ALU_BNE:  alu_branch = (alu_op1 != alu_op2);
            ALU_BLT:  alu_branch = ($signed(alu_op1) < $signed(alu_op2));
            ALU_BGE:  alu_branch = ($signed(alu_op1) >= $signed(alu_op2));
            ALU_BLTU: alu_branch = (alu_op1 < alu_op2);
            ALU_BGEU: alu_branch = (alu_op1 >= alu_op2);
            default:  alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input alu_ops_t c);
        req_op1[i*32 +: 32] = a;
        req_op2[i*32 +: 32] = b;
        req_ctrl[i]         = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        req_ctrl[0] = ALU_ADD;
        req_ctrl[1] = ALU_ADD;

        // Reset state
        do_reset();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_rsp_branch", 32'(rsp_branch), 32'h0);
        check("rst_alu_op1", alu_op1, 32'h0);
        check("rst_alu_op2", alu_op2, 32'h0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));

        // Single ADD: 5 + 7
        set_req(0, 32'h5, 32'h7, ALU_ADD);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        #1;
        check("add_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        #1;
        check("add_exec_ready", 32'(req_ready), 32'h0);
        check("add_alu_op1", alu_op1, 32'h5);
        check("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("add_rsp_valid", 32'(rsp_valid), 32'h1);
        check("add_rsp_result", rsp_result, 32'hC);
        check("add_rsp_branch", 32'(rsp_branch), 32'h0);
        tick();
        check("add_rsp_drop", 32'(rsp_valid), 32'h0);

        // Contention from reset: grants 0,1,0,1
        do_reset();
        set_req(0, 32'd10, 32'd3, ALU_SUB);
        set_req(1, 32'hF0, 32'h0F, ALU_XOR);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            check($sformatf("cont%0d_ready", k), 32'(req_ready), 32'(1) << e);
            tick();
            check($sformatf("cont%0d_exec_ready", k), 32'(req_ready), 32'h0);
            tick();
            check($sformatf("cont%0d_rsp_valid", k), 32'(rsp_valid), 32'(1) << e);
            check($sformatf("cont%0d_resp_ready", k), 32'(req_ready), 32'h0);
            check($sformatf("cont%0d_result", k), rsp_result, (e == 0) ? 32'h7 : 32'hFF);
            tick();
        end
        req_valid = 2'b00;

        // Response backpressure on BLT -1 < 0
        set_req(1, 32'hFFFF_FFFF, 32'h0, ALU_BLT);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        check("bp_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        set_req(0, 32'h1, 32'h2, ALU_ADD);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'h2);
            check($sformatf("bp%0d_branch", i), 32'(rsp_branch), 32'h1);
            check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        check("bp_handshake_valid", 32'(rsp_valid), 32'h2);
        check("bp_handshake_ready", 32'(req_ready), 32'h0);
        tick();
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check("bp_idle_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("bp_next_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp_next_result", rsp_result, 32'h3);
        tick();

        // Branch ops on equal operands
        set_req(0, 32'hA5, 32'hA5, ALU_BEQ);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        check("beq_rsp_valid", 32'(rsp_valid), 32'h1);
        check("beq_branch", 32'(rsp_branch), 32'h1);
        tick();
        set_req(0, 32'hA5, 32'hA5, ALU_BNE);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        check("bne_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bne_branch", 32'(rsp_branch), 32'h0);
        tick();

        // Reset during EXEC discards the operation
        set_req(1, 32'h1, 32'h1, ALU_ADD);
        req_valid = 2'b10;
        #1;
        check("rmid_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("rmid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rmid_alu_op1", alu_op1, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rmid%0d_no_rsp", i), 32'(rsp_valid), 32'h0);
            tick();
        end
        req_valid = 2'b11;
        set_req(0, 32'h2, 32'h2, ALU_ADD);
        #1;
        check("rmid_first_grant", 32'(req_ready), 32'h1);

`ifdef ALU_ARB_STATS_EN
        // Grants 0,1,0 then 0 alone
        check("stat_after_rst", stat_grant_cnt, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req_valid = 2'b01;
            #1;
            tick();
            tick();
            tick();
        end
        req_valid = 2'b00;
        #1;
        check("stat_counts", stat_grant_cnt, 32'h0001_0003);
        stat_clr  = 1'b1;
        req_valid = 2'b01;
        #1;
        tick();
        stat_clr  = 1'b0;
        req_valid = 2'b00;
        #1;
        check("stat_clr_priority", stat_grant_cnt, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
